// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Packed-BCD mm:ss countdown timer with load / start / pause
//               control, a one-second decrement driven by the tick pulse and
//               an alarm window lasting ALARM_TICKS ticks after expiry.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous, active-low reset
//               tick       - one-cycle count-enable pulse
//               load       - one-cycle preset load request
//               load_min   - preset minutes, packed BCD
//               load_sec   - preset seconds, packed BCD
//               start      - one-cycle run / resume request
//               pause      - one-cycle pause request
//               minutes    - remaining minutes, packed BCD (registered)
//               seconds    - remaining seconds, packed BCD (registered)
//               busy       - high while running or paused
//               sec_borrow - pulse when seconds wrap 00 -> 59
//               done       - pulse on reaching 00:00
//               alarm      - level, high during the alarm window
//               load_err   - pulse when a load is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       busy,
  output logic       sec_borrow,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state;
  logic [7:0] alarm_cnt;

  logic [7:0] dec_min;
  logic [7:0] dec_sec;
  logic       dec_borrow;
  logic       dec_zero;
  logic       load_valid;
  logic       value_nonzero;

  // One-second BCD decrement of the current value. Minutes are clamped at
  // 00 because the machine never stays in RUN at 00:00.
  always_comb begin
    dec_min    = minutes;
    dec_sec    = seconds;
    dec_borrow = 1'b0;
    if (seconds[3:0] != 4'd0) begin
      dec_sec[3:0] = seconds[3:0] - 4'd1;
    end else if (seconds[7:4] != 4'd0) begin
      dec_sec = {seconds[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec    = 8'h59;
      dec_borrow = 1'b1;
      if (minutes[3:0] != 4'd0) begin
        dec_min[3:0] = minutes[3:0] - 4'd1;
      end else if (minutes[7:4] != 4'd0) begin
        dec_min = {minutes[7:4] - 4'd1, 4'd9};
      end
    end
  end

  assign dec_zero      = (dec_min == 8'h00) && (dec_sec == 8'h00);
  assign value_nonzero = (minutes != 8'h00) || (seconds != 8'h00);

  // Tens digits are limited to 0-5 for both fields, units to 0-9.
  assign load_valid = (load_min[7:4] <= 4'd5) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      minutes    <= 8'h00;
      seconds    <= 8'h00;
      busy       <= 1'b0;
      sec_borrow <= 1'b0;
      done       <= 1'b0;
      alarm      <= 1'b0;
      load_err   <= 1'b0;
      alarm_cnt  <= 8'd0;
    end else begin
      sec_borrow <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;

      if (load) begin
        // A load owns the cycle: any tick, start or pause alongside it is dropped.
        if (load_valid) begin
          minutes   <= load_min;
          seconds   <= load_sec;
          state     <= IDLE;
          busy      <= 1'b0;
          alarm     <= 1'b0;
          alarm_cnt <= 8'd0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (tick) begin
              minutes    <= dec_min;
              seconds    <= dec_sec;
              sec_borrow <= dec_borrow;
              // Expiry takes precedence over a simultaneous pause.
              if (dec_zero) begin
                state     <= ALARM;
                done      <= 1'b1;
                alarm     <= 1'b1;
                busy      <= 1'b0;
                alarm_cnt <= 8'd0;
              end else if (pause) begin
                state <= PAUSE;
              end
            end else if (pause) begin
              state <= PAUSE;
            end
          end

          IDLE: begin
            if (start && !pause && value_nonzero) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end

          PAUSE: begin
            if (start && !pause) begin
              state <= RUN;
            end
          end

          ALARM: begin
            if (tick) begin
              if (alarm_cnt >= ALARM_LAST) begin
                state     <= IDLE;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
              end else begin
                alarm_cnt <= alarm_cnt + 8'd1;
              end
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter ALARM_TICKS, default 5, the number of tick pulses for which alarm stays high after expiry (range 1-255).
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port tick, input, 1, a one-cycle count-enable pulse (nominally 1 Hz).
REQ-005 The block SHALL have port load, input, 1, a one-cycle request to load the preset value.
REQ-006 The block SHALL have port load_min, input, 8, the preset minutes as packed BCD (tens [7:4], units [3:0]).
REQ-007 The block SHALL have port load_sec, input, 8, the preset seconds as packed BCD.
REQ-008 The block SHALL have port start, input, 1, a one-cycle run/resume request.
REQ-009 The block SHALL have port pause, input, 1, a one-cycle pause request.
REQ-010 The block SHALL have port minutes, output, 8, the remaining minutes as packed BCD (registered).
REQ-011 The block SHALL have port seconds, output, 8, the remaining seconds as packed BCD (registered).
REQ-012 The block SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-013 The block SHALL have port sec_borrow, output, 1, a one-cycle pulse when seconds wrap from 00 to 59.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse on reaching 00:00.
REQ-015 The block SHALL have port alarm, output, 1, a level held high during the alarm window.
REQ-016 The block SHALL have port load_err, output, 1, a one-cycle pulse when a load is rejected.

Function
REQ-017 The state machine SHALL have the states IDLE, RUN, PAUSE and ALARM, with exactly one state active at a time.
REQ-018 Input priority each cycle SHALL be: reset, then load, then pause, then start, then tick.
REQ-019 A load SHALL be valid only if every digit is 0-9, the minutes tens digit is 0-5, and the seconds tens digit is 0-5.
REQ-020 A valid load in any state SHALL copy load_min and load_sec to minutes and seconds, enter IDLE and clear alarm.
REQ-021 An invalid load SHALL pulse load_err for one cycle and leave the value and state unchanged.
REQ-022 A tick arriving in the same cycle as a load SHALL be dropped.
REQ-023 start in IDLE with a nonzero value SHALL enter RUN; start in IDLE with 00:00 SHALL be ignored.
REQ-024 start in PAUSE SHALL enter RUN; start in RUN or ALARM SHALL be ignored.
REQ-025 pause in RUN SHALL enter PAUSE; pause in any other state SHALL be ignored.
REQ-026 If start and pause are asserted together, pause SHALL win.
REQ-027 tick in RUN SHALL decrement the value by one second, with the result visible on the cycle after tick is sampled.
REQ-028 The decrement SHALL follow these rules:
- seconds units nonzero: units decrements.
- seconds units 0 and seconds tens nonzero: units becomes 9 and tens decrements.
- seconds 00: seconds becomes 59, sec_borrow pulses, and minutes decrements by the same BCD rules (units 0 gives units 9 and tens-1).
REQ-029 A tick that produces 00:00 SHALL pulse done and enter ALARM in the same update.
REQ-030 alarm SHALL be high in ALARM and SHALL stay high for exactly ALARM_TICKS ticks.
REQ-031 On the ALARM_TICKS-th tick the block SHALL clear alarm and enter IDLE.
REQ-032 tick SHALL not change minutes or seconds in IDLE, PAUSE or ALARM.
REQ-033 A tick together with pause in RUN SHALL perform the decrement and then enter PAUSE.
- If that decrement reaches 00:00, ALARM SHALL take precedence over PAUSE.
REQ-034 A tick together with start in IDLE or PAUSE SHALL enter RUN without decrementing.
REQ-035 Minutes SHALL never wrap below 00; the block SHALL leave RUN at 00:00.
REQ-036 done, sec_borrow and load_err SHALL each be high for exactly one cycle per event.

Reset
REQ-037 When reset is low at a rising edge, the block SHALL set minutes=8'h00, seconds=8'h00, state IDLE, and busy, sec_borrow, done, alarm and load_err all 0.
REQ-038 Reset mid-operation in any state SHALL abandon the count, and no done or alarm SHALL follow.
REQ-039 Reset SHALL override a load, start, pause or tick asserted in the same cycle.

Verification
REQ-040 Load 01:00, start, then 1 tick -> 00:59 with one sec_borrow pulse; after 59 more ticks -> 00:00, one done pulse, alarm high.
REQ-041 Default ALARM_TICKS, alarm active, 5 further ticks -> alarm falls on the 5th tick, state IDLE, busy=0.
REQ-042 Load 8'h6A / 8'h00 -> load_err pulses; value and state unchanged. Load 8'h00 / 8'h60 -> load_err pulses.
REQ-043 Load 00:10, start, 3 ticks -> 00:07. Then pause and tick in the same cycle -> 00:06 and PAUSE. Then 4 ticks -> 00:06. Then start, 1 tick -> 00:05.
REQ-044 Load 10:00, start, 1 tick -> 09:59. Load 00:05 in the same cycle as a tick -> 00:05, IDLE.
REQ-045 RUN at 00:03, assert reset low for 1 cycle -> 00:00, IDLE; 10 ticks -> no done pulse and alarm stays 0.
